// File: rtl/vga_scroll_animator_pkg.sv
// rtl/vga_scroll_animator_pkg.sv - shared widths, FSM states and default velocity table
package vga_anim_pkg;

   localparam int FRAC_W     = 4;
   localparam int ACC_W      = 10 + FRAC_W;
   localparam int NUM_LAYERS = 5;
   localparam int NUM_ACC    = 2 * NUM_LAYERS;
   localparam int VEL_W      = 10;
   localparam int OFF_W      = 10 * NUM_LAYERS;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UPDATE = 2'd1,
      DONE   = 2'd2
   } state_e;

   typedef logic [ACC_W-1:0] acc_t;

   // Velocities are Q6.FRAC_W pixels per frame
   localparam logic [VEL_W-1:0] DEF_VX0 = 10'd256;
   localparam logic [VEL_W-1:0] DEF_VY0 = 10'd32;
   localparam logic [VEL_W-1:0] DEF_VX1 = 10'd112;
   localparam logic [VEL_W-1:0] DEF_VY1 = 10'd24;
   localparam logic [VEL_W-1:0] DEF_VX2 = 10'd64;
   localparam logic [VEL_W-1:0] DEF_VY2 = 10'd8;
   localparam logic [VEL_W-1:0] DEF_VX3 = 10'd32;
   localparam logic [VEL_W-1:0] DEF_VY3 = 10'd4;
   localparam logic [VEL_W-1:0] DEF_VX4 = 10'd8;
   localparam logic [VEL_W-1:0] DEF_VY4 = 10'd3;

endpackage

// File: rtl/vga_scroll_animator_if.sv
// rtl/vga_scroll_animator_if.sv - control inputs and offset outputs of the scroll animator
interface vga_scroll_animator_if;
   import vga_anim_pkg::*;

   logic             vsync;
   logic             pause;
   logic             dir;
   logic [1:0]       speed;
   logic             step;
   logic [OFF_W-1:0] off_x;
   logic [OFF_W-1:0] off_y;
   logic [9:0]       frame_count;
   logic             busy;

   modport master (
      output vsync, pause, dir, speed, step,
      input  off_x, off_y, frame_count, busy
   );

   modport slave (
      input  vsync, pause, dir, speed, step,
      output off_x, off_y, frame_count, busy
   );

endinterface

// File: rtl/vga_anim_accum_alu.sv
// rtl/vga_anim_accum_alu.sv - shared adder: acc +/- (vel << speed), wrapping at ACC_W bits
module vga_anim_accum_alu
   import vga_anim_pkg::*;
(
   input  logic [ACC_W-1:0] acc,
   input  logic [VEL_W-1:0] vel,
   input  logic [1:0]       speed,
   input  logic             dir,
   output logic [ACC_W-1:0] result
);

   logic [ACC_W-1:0] delta;

   always_comb begin
      delta  = acc_t'(vel) << speed;
      result = dir ? (acc - delta) : (acc + delta);
   end

endmodule

// File: rtl/vga_scroll_animator.sv
// rtl/vga_scroll_animator.sv - per-frame parallax scroll offset sequencer
// Optional single-step while paused: define VGA_SCROLL_STEP_EN.
module vga_scroll_animator
   import vga_anim_pkg::*;
#(
   parameter logic [VEL_W-1:0] VX0 = DEF_VX0,
   parameter logic [VEL_W-1:0] VY0 = DEF_VY0,
   parameter logic [VEL_W-1:0] VX1 = DEF_VX1,
   parameter logic [VEL_W-1:0] VY1 = DEF_VY1,
   parameter logic [VEL_W-1:0] VX2 = DEF_VX2,
   parameter logic [VEL_W-1:0] VY2 = DEF_VY2,
   parameter logic [VEL_W-1:0] VX3 = DEF_VX3,
   parameter logic [VEL_W-1:0] VY3 = DEF_VY3,
   parameter logic [VEL_W-1:0] VX4 = DEF_VX4,
   parameter logic [VEL_W-1:0] VY4 = DEF_VY4
)(
   input  logic                   clk,
   input  logic                   rst_n,
   vga_scroll_animator_if.slave   io
);

   localparam logic [1:0] S_IDLE   = IDLE;
   localparam logic [1:0] S_UPDATE = UPDATE;
   localparam logic [1:0] S_DONE   = DONE;
   localparam logic [3:0] LAST_IDX = 4'(NUM_ACC - 1);

   logic [1:0]       state;
   logic [3:0]       idx;
   acc_t             acc [NUM_ACC];
   logic             vsync_q;
   logic             tick;
   logic             step_pend;
   logic             advance;
   logic             busy;
   logic [9:0]       frame_count;
   logic [VEL_W-1:0] vel_sel;
   acc_t             acc_cur;
   acc_t             acc_next;
   logic [OFF_W-1:0] off_x;
   logic [OFF_W-1:0] off_y;

   assign tick    = io.vsync & ~vsync_q;
   assign advance = ~io.pause | step_pend;

   always_ff @(posedge clk) begin
      if (!rst_n) vsync_q <= 1'b0;
      else        vsync_q <= io.vsync;
   end

`ifdef VGA_SCROLL_STEP_EN
   logic step_q;
   logic consumed;

   // A new step edge wins over the clear, so a request arriving in DONE is kept
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         step_q    <= 1'b0;
         step_pend <= 1'b0;
         consumed  <= 1'b0;
      end else begin
         step_q    <= io.step;
         step_pend <= (step_pend & ~((state == S_DONE) & consumed)) | (io.step & ~step_q);
         if (state == S_IDLE && tick && advance)
            consumed <= io.pause & step_pend;
      end
   end
`else
   logic unused_step;
   assign unused_step = io.step;
   assign step_pend   = 1'b0;
`endif

   // Order: X of layers 0..4, then Y of layers 0..4
   always_comb begin
      vel_sel = '0;
      case (idx)
         4'd0:    vel_sel = VX0;
         4'd1:    vel_sel = VX1;
         4'd2:    vel_sel = VX2;
         4'd3:    vel_sel = VX3;
         4'd4:    vel_sel = VX4;
         4'd5:    vel_sel = VY0;
         4'd6:    vel_sel = VY1;
         4'd7:    vel_sel = VY2;
         4'd8:    vel_sel = VY3;
         4'd9:    vel_sel = VY4;
         default: vel_sel = '0;
      endcase
   end

   assign acc_cur = acc[idx];

   vga_anim_accum_alu u_alu (
      .acc    (acc_cur),
      .vel    (vel_sel),
      .speed  (io.speed),
      .dir    (io.dir),
      .result (acc_next)
   );

   // busy drops with the last write so it spans exactly the ten update cycles
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         idx         <= '0;
         busy        <= 1'b0;
         frame_count <= '0;
         for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (tick && advance) begin
                  state <= S_UPDATE;
                  idx   <= '0;
                  busy  <= 1'b1;
               end
            end
            S_UPDATE: begin
               acc[idx] <= acc_next;
               if (idx == LAST_IDX) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
               end else begin
                  idx <= idx + 4'd1;
               end
            end
            S_DONE: begin
               frame_count <= frame_count + 10'd1;
               busy        <= 1'b0;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      off_x = '0;
      off_y = '0;
      for (int l = 0; l < NUM_LAYERS; l++) begin
         off_x[l*10 +: 10] = acc[l][ACC_W-1:FRAC_W];
         off_y[l*10 +: 10] = acc[l+NUM_LAYERS][ACC_W-1:FRAC_W];
      end
   end

   assign io.off_x       = off_x;
   assign io.off_y       = off_y;
   assign io.frame_count = frame_count;
   assign io.busy        = busy;

endmodule
